// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised VGA raster timing generator running on the board
//           clock with a pixel-enable strobe instead of a divided clock.
// Revision: 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 11,
  parameter int FW       = 16
) (
  input  logic          CLK100MHZ,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_end,
  output logic          frame_end,
  output logic          vblank_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
  localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
  localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_v_act_last = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (longint'(c_h_total) > (longint'(1) << CW)) begin : g_chk_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (longint'(c_v_total) > (longint'(1) << CW)) begin : g_chk_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic          w_pix_en;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_line_end;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic [FW-1:0] r_frame_cnt;

  // rst gates the strobe so nothing fires while reset is held, even at CLK_DIV=1
  if (CLK_DIV == 1) begin : g_div_bypass
    assign w_pix_en = en && !rst;
  end else begin : g_div_cnt
    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    logic [c_dw-1:0] r_div_cnt;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
        r_div_cnt <= '0;
      end else if (en) begin
        r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_dw'(1);
      end
    end

    assign w_pix_en = en && !rst && (r_div_cnt == c_div_last);
  end

  always_comb begin
    w_h_wrap = (r_hcount == c_h_last);
    w_v_wrap = (r_vcount == c_v_last);
    w_h_next = w_h_wrap ? '0 : r_hcount + CW'(1);
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_vcount + CW'(1);
    end
  end

  // Decode from the next counter values so sync/active track the counters with no skew
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_active    <= 1'b1;
      r_frame_cnt <= '0;
    end else if (w_pix_en) begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= ((w_h_next >= c_hs_start) && (w_h_next < c_hs_end)) ? HS_POL : ~HS_POL;
      r_vsync  <= ((w_v_next >= c_vs_start) && (w_v_next < c_vs_end)) ? VS_POL : ~VS_POL;
      r_active <= (w_h_next < c_h_act) && (w_v_next < c_v_act);
      if (w_h_wrap && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign w_line_end   = w_pix_en && w_h_wrap;
  assign pix_en       = w_pix_en;
  assign line_end     = w_line_end;
  assign frame_end    = w_line_end && w_v_wrap;
  assign vblank_start = w_line_end && (r_vcount == c_v_act_last);
  assign hcount       = r_hcount;
  assign vcount       = r_vcount;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign active       = r_active;
  assign frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Self-checking bench: small raster against a pixel-index model,
//           plus default-parameter line timing.
// Revision: 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int c_ht  = 16;
  localparam int c_vt  = 8;
  localparam int c_div = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic rst_d = 1'b1;
  logic en_d  = 1'b1;

  logic        pix_en, hsync, vsync, active, line_end, frame_end, vblank_start;
  logic [10:0] hcount, vcount;
  logic [1:0]  frame_cnt;

  logic        d_pix_en, d_hsync, d_vsync, d_active, d_line_end, d_frame_end, d_vblank_start;
  logic [10:0] d_hcount, d_vcount;
  logic [1:0]  d_frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2), .CW(11), .FW(2)
  ) u_dut (
    .CLK100MHZ(clk), .rst(rst), .en(en), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .active(active), .line_end(line_end), .frame_end(frame_end),
    .vblank_start(vblank_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(.FW(2)) u_dut_def (
    .CLK100MHZ(clk), .rst(rst_d), .en(en_d), .pix_en(d_pix_en),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .active(d_active), .line_end(d_line_end), .frame_end(d_frame_end),
    .vblank_start(d_vblank_start), .frame_cnt(d_frame_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: count enabled clocks and pixels; everything else is arithmetic on the pixel index
  int ec = 0;
  int np = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ec <= 0;
      np <= 0;
    end else if (en) begin
      ec <= ec + 1;
      if (ec % c_div == c_div - 1) np <= np + 1;
    end
  end

  always @(negedge clk) begin
    int h, v, f;
    logic pe, le, fe, vb, hs, vs, ac;
    logic [30:0] got, exp;
    h  = np % c_ht;
    v  = (np / c_ht) % c_vt;
    f  = (np / (c_ht * c_vt)) % 4;
    pe = !rst && en && (ec % c_div == c_div - 1);
    le = pe && (h == c_ht - 1);
    fe = le && (v == c_vt - 1);
    vb = le && (v == 3);
    hs = (h >= 10) && (h < 13);
    vs = (v >= 5) && (v < 7);
    ac = (h < 8) && (v < 4);
    got = {pix_en, line_end, frame_end, vblank_start, hsync, vsync, active, hcount, vcount, frame_cnt};
    exp = {pe, le, fe, vb, hs, vs, ac, 11'(h), 11'(v), 2'(f)};
    check("cycle_model", got, exp);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_clk = 0, act_clk = 0, le_cnt = 0, le_h = -1;
    int vs_clk = 0, vb_cnt = 0, vb_h = -1, vb_v = -1, fe_cnt = 0, fe_h = -1, fe_v = -1;
    int d_low = 0, d_first_h = -1, d_last_h = -1, d_act = 0, d_le1 = -1, d_le2 = -1;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_d = 1'b0;

    fork
      begin : main_seq
        for (int i = 1; i <= 1024; i++) begin
          @(negedge clk);
          if (i == 1) begin
            check("startup_pix_en_c1", pix_en, 0);
            check("startup_hcount", hcount, 0);
            check("startup_active", active, 1);
            check("startup_hsync", hsync, 0);
            check("startup_vsync", vsync, 0);
          end
          if (i == 2) begin
            check("first_pix_en_c2", pix_en, 1);
            check("hcount_c2", hcount, 0);
          end
          if (i == 3) begin
            check("hcount_c3", hcount, 1);
            check("pix_en_c3", pix_en, 0);
          end
          if (i == 33) begin
            check("line1_vcount", vcount, 1);
            check("line1_hcount", hcount, 0);
          end
          if (i <= 32) begin
            hs_clk  += int'(hsync);
            act_clk += int'(active);
            if (line_end) begin le_cnt++; le_h = int'(hcount); end
          end
          if (i <= 512) begin
            vs_clk += int'(vsync);
            if (vblank_start) begin vb_cnt++; vb_h = int'(hcount); vb_v = int'(vcount); end
            if (frame_end) begin fe_cnt++; fe_h = int'(hcount); fe_v = int'(vcount); end
          end
          if (i == 257)  check("frame_cnt_1", frame_cnt, 1);
          if (i == 513)  check("frame_cnt_2", frame_cnt, 2);
          if (i == 769)  check("frame_cnt_3", frame_cnt, 3);
          if (i == 1024) check("frame_end_4th", {frame_end, frame_cnt}, {1'b1, 2'd3});
        end
        check("line_hsync_clocks", hs_clk, 6);
        check("line_active_clocks", act_clk, 16);
        check("line_end_count", le_cnt, 1);
        check("line_end_hcount", le_h, 15);
        check("vsync_clocks_2frames", vs_clk, 128);
        check("vblank_count", vb_cnt, 2);
        check("vblank_pos", {vb_h, vb_v}, {32'd15, 32'd3});
        check("frame_end_count", fe_cnt, 2);
        check("frame_end_pos", {fe_h, fe_v}, {32'd15, 32'd7});
        @(negedge clk);
        check("frame_cnt_wrap", frame_cnt, 0);

        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
          if (hcount == 11'd6 && !pix_en) found = 1'b1;
          else @(negedge clk);
        end
        check("reach_hcount6", found, 1);
        @(posedge clk);
        #1 en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("freeze_hold", {hcount, pix_en, line_end, frame_end, vblank_start, hsync, active},
                {11'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        check("resume_phase", {pix_en, hcount}, {1'b1, 11'd6});
        @(negedge clk);
        check("resume_advance", {pix_en, hcount}, {1'b0, 11'd7});

        found = 1'b0;
        for (int k = 0; k < 800 && !found; k++) begin
          if (hcount == 11'd9 && vcount == 11'd5 && frame_cnt == 2'd1) found = 1'b1;
          else @(negedge clk);
        end
        check("reach_9_5", found, 1);
        check("pre_rst_state", {vsync, active}, {1'b1, 1'b0});
        #2 rst = 1'b1;
        #1;
        check("async_rst", {hcount, vcount, frame_cnt, active, hsync, vsync, pix_en, line_end},
              {11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
      end
      begin : def_seq
        for (int i = 1; i <= 6500; i++) begin
          @(negedge clk);
          if (i == 1) check("def_reset_syncs", {d_hsync, d_vsync, d_active}, {1'b1, 1'b1, 1'b1});
          if (i <= 3200) begin
            if (!d_hsync) begin
              d_low++;
              if (d_first_h < 0) d_first_h = int'(d_hcount);
              d_last_h = int'(d_hcount);
            end
            d_act += int'(d_active);
          end
          if (d_line_end) begin
            if (d_le1 < 0) d_le1 = i;
            else if (d_le2 < 0) d_le2 = i;
          end
        end
        check("def_first_line_end", d_le1, 3200);
        check("def_line_period", d_le2 - d_le1, 3200);
        check("def_hsync_low_clocks", d_low, 384);
        check("def_hsync_first_h", d_first_h, 656);
        check("def_hsync_last_h", d_last_h, 751);
        check("def_active_clocks", d_act, 2560);
        check("def_vcount_line2", d_vcount, 2);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 controller and the separate clock divider in the display path. It runs directly on the 100 MHz board clock and produces a pixel-enable strobe, so no derived clock is needed. It drives hsync/vsync, an active-video flag, pixel coordinates, per-line and per-frame strobes, and a vblank-start tick for game-state updates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level
- CLK_DIV, 4, CLK100MHZ cycles per pixel (≥1)
- CW, 11, width of hcount/vcount
- FW, 16, width of frame_cnt

Ports:
- CLK100MHZ  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; 0 freezes all state
- pix_en  out  1  one-cycle pixel strobe
- hcount  out  CW  current column, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- active  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
- line_end  out  1  strobe on last pixel of a line
- frame_end  out  1  strobe on last pixel of a frame
- vblank_start  out  1  strobe on last pixel of the last active line
- frame_cnt  out  FW  completed-frame counter

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Both totals must fit in CW bits. This is checked at elaboration with $error.
- Divider div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_en = en && div_cnt==CLK_DIV-1 (combinational).
  - When CLK_DIV=1, pix_en = en.
- On each edge with pix_en=1:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At V_TOTAL-1, vcount wraps to 0 and frame_cnt increments modulo 2^FW.
- Registered decode: hsync, vsync and active are registered. They are computed from the next counter values on the same edge, so all outputs always describe the same pixel (zero relative skew).
- hsync asserted when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. vsync transitions are aligned to hcount=0.
- Strobes are combinational, exactly one clock wide, and coincide with pix_en:
  - line_end = pix_en && hcount==H_TOTAL-1.
  - frame_end = line_end && vcount==V_TOTAL-1.
  - vblank_start = line_end && vcount==V_ACTIVE-1.
- Freeze (en=0):
  - div_cnt, the counters, sync, active and frame_cnt hold.
  - pix_en and all strobes are 0.
  - Resuming continues from the held div_cnt with no lost or extra pixel.

## Timing
- Reset values (asynchronous):
  - div_cnt=0, hcount=0, vcount=0, frame_cnt=0.
  - active=1, hsync=~HS_POL, vsync=~VS_POL.
  - pix_en and all strobes are 0 while rst=1.
- After rst deasserts with en=1, the first pix_en occurs in clock CLK_DIV (1-based). hcount becomes 1 on that edge.
- Pixel period is CLK_DIV clocks. Line period is H_TOTAL·CLK_DIV clocks. Frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks.
- Sync/active latency from a counter change is 0 clocks: they update on the same edge as the counters.
- Simultaneous line_end and frame_end (or line_end and vblank_start) are legal and expected.
- Reset asserted mid-frame returns all state to reset values immediately. No partial strobe is emitted.
- Default parameters give 800x525 at 25 MHz, which is standard 640x480@60 with negative syncs.

## Test plan
Small configuration: H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), CLK_DIV=2, positive polarities.

- **Reset/startup:** release rst, en=1 → pix_en first high in clock 2, then every 2nd clock. hcount reaches 1 after clock 2. Before that, active=1, hsync=0, vsync=0.
- **Line timing:** run one line → hsync=1 exactly for hcount 10..12 (6 clocks). active=1 for hcount 0..7. One line_end at hcount=15. Next line starts with vcount=1.
- **Frame timing:** run two frames (512 clocks) → vsync=1 for vcount 5..6, each a whole line. vblank_start once per frame at (15,3). frame_end once at (15,7). frame_cnt goes 0→1→2.
- **Freeze:** drop en for 5 clocks mid-line at hcount=6 → all outputs hold and no strobes fire. After resume, the next pix_en falls at the same div phase and hcount continues 6→7.
- **Async reset mid-frame:** assert rst at (9,5) between clock edges → outputs return to reset values without waiting for a clock edge. frame_cnt=0.
- **Defaults/wrap:** default parameters with FW=2 → line period 3200 clocks and frame period 1,680,000 clocks. hsync low for hcount 656..751. frame_cnt wraps 3→0 after the 4th frame.
